// File: rtl/sram_bridge.sv
// Bridge between a clock-enabled CPU core and an asynchronous SRAM, plus one I/O port.
// Every core bus cycle is SETUP, WAIT ACCESS clocks, then ACK, which pulses core_ce.
module sram_bridge #(
  parameter int          WAIT    = 2,
  parameter logic [15:0] ROM_TOP = 16'h3FFF,
  parameter logic [15:0] IO_ADDR = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] core_address,
  input  logic [7:0]  core_out,
  input  logic        core_we,
  output logic [7:0]  core_in,
  output logic        core_ce,
  output logic [15:0] sram_a,
  output logic [7:0]  sram_d_o,
  input  logic [7:0]  sram_d_i,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic [7:0]  port_out,
  output logic        port_stb,
  input  logic [7:0]  port_in,
  output logic        wp_fault
);

  localparam logic [3:0] WAIT_L = 4'(WAIT);

  typedef enum logic [1:0] {
    SETUP  = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t     state_r;
  logic [3:0] cnt_r;
  logic       we_r;
  logic       is_io_r;
  logic       is_rom_r;
  logic       is_io_s;
  logic       is_rom_s;

  // Address decode of the (frozen) core address; the I/O address wins over ROM.
  always_comb begin
    is_io_s  = 1'b0;
    is_rom_s = 1'b0;
    if (core_address == IO_ADDR) begin
      is_io_s = 1'b1;
    end else if (core_address <= ROM_TOP) begin
      is_rom_s = 1'b1;
    end else begin
      is_io_s  = 1'b0;
      is_rom_s = 1'b0;
    end
  end

  // Bus-cycle sequencer; every output is registered here.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= SETUP;
      cnt_r     <= 4'd0;
      we_r      <= 1'b0;
      is_io_r   <= 1'b0;
      is_rom_r  <= 1'b0;
      core_in   <= 8'h00;
      core_ce   <= 1'b0;
      sram_a    <= 16'h0000;
      sram_d_o  <= 8'h00;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      port_out  <= 8'h00;
      port_stb  <= 1'b0;
      wp_fault  <= 1'b0;
    end else begin
      case (state_r)
        SETUP: begin
          we_r      <= core_we;
          is_io_r   <= is_io_s;
          is_rom_r  <= is_rom_s;
          sram_a    <= core_address;
          sram_d_o  <= core_out;
          cnt_r     <= WAIT_L;
          core_ce   <= 1'b0;
          port_stb  <= 1'b0;
          // Strobes for the first ACCESS clock; ROM writes never assert we_n.
          sram_ce_n <= is_io_s;
          sram_oe_n <= is_io_s | core_we;
          sram_we_n <= is_io_s | is_rom_s | ~core_we;
          state_r   <= ACCESS;
        end
        ACCESS: begin
          if (cnt_r == 4'd1) begin
            state_r   <= ACK;
            cnt_r     <= 4'd0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            core_ce   <= 1'b1;
            if (!we_r) begin
              core_in <= is_io_r ? port_in : sram_d_i;
            end else if (is_io_r) begin
              port_out <= sram_d_o;
              port_stb <= 1'b1;
            end else if (is_rom_r) begin
              wp_fault <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r - 4'd1;
            // Release we_n one clock early so data is held past the write edge.
            if (cnt_r == 4'd2) begin
              sram_we_n <= 1'b1;
            end
          end
        end
        ACK: begin
          core_ce  <= 1'b0;
          port_stb <= 1'b0;
          state_r  <= SETUP;
        end
        default: begin
          state_r   <= SETUP;
          core_ce   <= 1'b0;
          port_stb  <= 1'b0;
          sram_ce_n <= 1'b1;
          sram_oe_n <= 1'b1;
          sram_we_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bridge.sv
// Scoreboard bench for sram_bridge (WAIT=2): the driver queues expected ACK-time results,
// the monitor checks them plus the 4-clock strobe trace whenever core_ce pulses.
module tb_sram_bridge;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] core_address = 16'h0000;
  logic [7:0]  core_out = 8'h00;
  logic        core_we = 1'b0;
  logic [7:0]  core_in;
  logic        core_ce;
  logic [15:0] sram_a;
  logic [7:0]  sram_d_o;
  logic [7:0]  sram_d_i = 8'h00;
  logic        sram_ce_n, sram_oe_n, sram_we_n;
  logic [7:0]  port_out;
  logic        port_stb;
  logic [7:0]  port_in = 8'h00;
  logic        wp_fault;

  sram_bridge #(.WAIT(2), .ROM_TOP(16'h3FFF), .IO_ADDR(16'hFFFF)) dut (
    .clock(clock), .reset(reset),
    .core_address(core_address), .core_out(core_out), .core_we(core_we),
    .core_in(core_in), .core_ce(core_ce),
    .sram_a(sram_a), .sram_d_o(sram_d_o), .sram_d_i(sram_d_i),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .port_out(port_out), .port_stb(port_stb), .port_in(port_in),
    .wp_fault(wp_fault)
  );

  always #5 clock = ~clock;

  // {ce_n,oe_n,we_n} for clocks SETUP, ACCESS1, ACCESS2, ACK
  localparam logic [11:0] TR_RD  = {3'b111, 3'b001, 3'b001, 3'b111};
  localparam logic [11:0] TR_RAMW = {3'b111, 3'b010, 3'b011, 3'b111};
  localparam logic [11:0] TR_ROMW = {3'b111, 3'b011, 3'b011, 3'b111};
  localparam logic [11:0] TR_IO  = {3'b111, 3'b111, 3'b111, 3'b111};

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  cin;
    logic [7:0]  pout;
    logic        stb;
    logic        wp;
    logic [11:0] trace;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_core_in"}, 32'(core_in), 32'h00);
    chk({nm, "_core_ce"}, 32'(core_ce), 32'h0);
    chk({nm, "_sram_a"}, 32'(sram_a), 32'h0000);
    chk({nm, "_sram_d_o"}, 32'(sram_d_o), 32'h00);
    chk({nm, "_strobes"}, 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'h7);
    chk({nm, "_port_out"}, 32'(port_out), 32'h00);
    chk({nm, "_port_stb"}, 32'(port_stb), 32'h0);
    chk({nm, "_wp_fault"}, 32'(wp_fault), 32'h0);
  endtask

  task automatic issue(input string nm, input logic [15:0] a, input logic [7:0] d, input logic w,
                       input logic [7:0] di, input logic [7:0] pi, input logic [7:0] cin,
                       input logic [7:0] pout, input logic stb, input logic wp,
                       input logic [11:0] tr, input bit push);
    exp_t e;
    core_address = a; core_out = d; core_we = w; sram_d_i = di; port_in = pi;
    e.name = nm; e.a = a; e.d = d; e.cin = cin; e.pout = pout; e.stb = stb; e.wp = wp; e.trace = tr;
    if (push) exp_q.push_back(e);
  endtask

  task automatic wait_ack(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (core_ce === 1'b1) seen = 1'b1;
    end
    if (!seen) chk({nm, "_ack_timeout"}, 32'(seen), 32'h1);
  endtask

  // Monitor: records strobes every clock, checks a queued transaction at each ACK.
  initial begin : monitor
    logic [11:0] hist = 12'hFFF;
    int          cyc = 0;
    exp_t        e;
    forever begin
      @(negedge clock);
      hist = {hist[8:0], sram_ce_n, sram_oe_n, sram_we_n};
      if (reset) begin
        cyc = 0;
      end else begin
        cyc++;
        if (core_ce === 1'b1) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_ack", 32'(exp_q.size()), 32'h1);
          end else begin
            e = exp_q.pop_front();
            chk({e.name, "_cycle_len"}, 32'(cyc), 32'd4);
            chk({e.name, "_trace"}, 32'(hist), 32'(e.trace));
            chk({e.name, "_core_in"}, 32'(core_in), 32'(e.cin));
            chk({e.name, "_port_out"}, 32'(port_out), 32'(e.pout));
            chk({e.name, "_port_stb"}, 32'(port_stb), 32'(e.stb));
            chk({e.name, "_wp_fault"}, 32'(wp_fault), 32'(e.wp));
            chk({e.name, "_sram_a"}, 32'(sram_a), 32'(e.a));
            chk({e.name, "_sram_d_o"}, 32'(sram_d_o), 32'(e.d));
          end
          cyc = 0;
        end else begin
          chk("port_stb_outside_ack", 32'(port_stb), 32'h0);
        end
      end
    end
  end

  initial begin : driver
    issue("rd_1234", 16'h1234, 8'h00, 1'b0, 8'hA5, 8'h00, 8'hA5, 8'h00, 1'b0, 1'b0, TR_RD, 1'b1);
    repeat (2) @(posedge clock);
    #1 check_reset("rst0");
    reset = 1'b0;
    wait_ack("rd_1234");

    @(posedge clock); #1
    issue("ramw_8000", 16'h8000, 8'h5A, 1'b1, 8'h00, 8'h00, 8'hA5, 8'h00, 1'b0, 1'b0, TR_RAMW, 1'b1);
    wait_ack("ramw_8000");
    @(posedge clock); #1
    issue("romw_0100", 16'h0100, 8'h11, 1'b1, 8'h00, 8'h00, 8'hA5, 8'h00, 1'b0, 1'b1, TR_ROMW, 1'b1);
    wait_ack("romw_0100");
    @(posedge clock); #1
    issue("iow_ffff", 16'hFFFF, 8'h3C, 1'b1, 8'h00, 8'h00, 8'hA5, 8'h3C, 1'b1, 1'b1, TR_IO, 1'b1);
    wait_ack("iow_ffff");
    @(posedge clock); #1
    issue("ior_ffff", 16'hFFFF, 8'h00, 1'b0, 8'h11, 8'h77, 8'h77, 8'h3C, 1'b0, 1'b1, TR_IO, 1'b1);
    wait_ack("ior_ffff");
    @(posedge clock); #1
    issue("romw_3fff", 16'h3FFF, 8'h22, 1'b1, 8'h00, 8'h00, 8'h77, 8'h3C, 1'b0, 1'b1, TR_ROMW, 1'b1);
    wait_ack("romw_3fff");
    @(posedge clock); #1
    issue("rd_4000", 16'h4000, 8'h00, 1'b0, 8'hC3, 8'h55, 8'hC3, 8'h3C, 1'b0, 1'b1, TR_RD, 1'b1);
    wait_ack("rd_4000");
    @(posedge clock); #1
    issue("ramw_4000", 16'h4000, 8'h99, 1'b1, 8'h00, 8'h00, 8'hC3, 8'h3C, 1'b0, 1'b1, TR_RAMW, 1'b1);
    wait_ack("ramw_4000");
    @(posedge clock); #1
    issue("rd_0000", 16'h0000, 8'h00, 1'b0, 8'h0F, 8'h00, 8'h0F, 8'h3C, 1'b0, 1'b1, TR_RD, 1'b1);
    wait_ack("rd_0000");
    @(posedge clock); #1
    issue("rd_fffe", 16'hFFFE, 8'h00, 1'b0, 8'h81, 8'h66, 8'h81, 8'h3C, 1'b0, 1'b1, TR_RD, 1'b1);
    wait_ack("rd_fffe");

    // RAM write aborted by reset in its first ACCESS clock; nothing is queued for it.
    @(posedge clock); #1
    issue("abort_w", 16'h8000, 8'hE7, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, TR_RAMW, 1'b0);
    @(posedge clock); #1
    chk("abort_we_low_before", 32'(sram_we_n), 32'h0);
    #2 reset = 1'b1;
    #1 check_reset("abort");
    repeat (2) @(posedge clock);
    #1 check_reset("abort_held");
    issue("rd_after_rst", 16'h1234, 8'h00, 1'b0, 8'hA5, 8'h00, 8'hA5, 8'h00, 1'b0, 1'b0, TR_RD, 1'b1);
    reset = 1'b0;
    wait_ack("rd_after_rst");

    @(posedge clock); #1
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
